// File: rtl/contador_progressivo.sv
// Up-counter M:SS in BCD with start/pause, synchronous clear and a target time.
// Stops in FIM on a target match or when it reaches the MAX_MIN:59 ceiling.
module contador_progressivo #(
    parameter int MAX_MIN = 9
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       botao,
    input  logic       limpa,
    input  logic [3:0] alvo_min,
    input  logic [2:0] alvo_dez,
    input  logic [3:0] alvo_uni,
    output logic [3:0] min,
    output logic [2:0] dez,
    output logic [3:0] uni,
    output logic       rodando,
    output logic       fim
);

    typedef enum logic [1:0] {PARADO, CONTANDO, FIM} state_t;

    localparam logic [3:0] MIN_TOP = 4'(MAX_MIN);

    state_t     state_q, state_d;
    logic [3:0] min_q, min_d;
    logic [2:0] dez_q, dez_d;
    logic [3:0] uni_q, uni_d;

    logic       alvo_ok;
    logic       match_now;
    logic       match_inc;
    logic       teto;
    logic [3:0] min_inc;
    logic [2:0] dez_inc;
    logic [3:0] uni_inc;

    // An out-of-range target digit disables matching entirely.
    assign alvo_ok   = (alvo_uni <= 4'd9) && (alvo_dez <= 3'd5) && (alvo_min <= MIN_TOP);
    assign match_now = alvo_ok && (alvo_min == min_q) && (alvo_dez == dez_q) && (alvo_uni == uni_q);
    assign teto      = (min_q == MIN_TOP) && (dez_q == 3'd5) && (uni_q == 4'd9);

    always_comb begin
        min_inc = min_q;
        dez_inc = dez_q;
        uni_inc = uni_q + 4'd1;
        if (uni_q == 4'd9) begin
            uni_inc = 4'd0;
            dez_inc = dez_q + 3'd1;
            if (dez_q == 3'd5) begin
                dez_inc = 3'd0;
                min_inc = min_q + 4'd1;
            end
        end
    end

    assign match_inc = alvo_ok && (alvo_min == min_inc) && (alvo_dez == dez_inc) && (alvo_uni == uni_inc);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        dez_d   = dez_q;
        uni_d   = uni_q;
        if (limpa) begin
            state_d = PARADO;
            min_d   = 4'd0;
            dez_d   = 3'd0;
            uni_d   = 4'd0;
        end else begin
            case (state_q)
                PARADO: begin
                    if (botao) state_d = match_now ? FIM : CONTANDO;
                end
                CONTANDO: begin
                    if (botao) begin
                        state_d = PARADO;
                    end else if (tick) begin
                        // At the ceiling the digits hold instead of wrapping.
                        if (teto) begin
                            state_d = FIM;
                        end else begin
                            min_d = min_inc;
                            dez_d = dez_inc;
                            uni_d = uni_inc;
                            if (match_inc) state_d = FIM;
                        end
                    end
                end
                FIM: state_d = FIM;
                default: state_d = PARADO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= PARADO;
            min_q   <= 4'd0;
            dez_q   <= 3'd0;
            uni_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            dez_q   <= dez_d;
            uni_q   <= uni_d;
        end
    end

    assign min     = min_q;
    assign dez     = dez_q;
    assign uni     = uni_q;
    assign rodando = (state_q == CONTANDO);
    assign fim     = (state_q == FIM);

endmodule

// File: tb/tb_contador_progressivo.sv
// Bench for contador_progressivo: directed scenarios plus random traffic,
// checked against a seconds-based reference model.
module tb_contador_progressivo;

    localparam int MAX_MIN = 9;
    localparam int MAX_SEC = MAX_MIN * 60 + 59;

    logic       clock;
    logic       resetn;
    logic       tick, botao, limpa;
    logic [3:0] alvo_min;
    logic [2:0] alvo_dez;
    logic [3:0] alvo_uni;
    logic [3:0] min;
    logic [2:0] dez;
    logic [3:0] uni;
    logic       rodando, fim;

    contador_progressivo #(.MAX_MIN(MAX_MIN)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .tick     (tick),
        .botao    (botao),
        .limpa    (limpa),
        .alvo_min (alvo_min),
        .alvo_dez (alvo_dez),
        .alvo_uni (alvo_uni),
        .min      (min),
        .dez      (dez),
        .uni      (uni),
        .rodando  (rodando),
        .fim      (fim)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed time as plain seconds, state 0=stopped 1=running 2=done
    int m_sec = 0;
    int m_st  = 0;

    logic [12:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int tgt_sec();
        if (alvo_uni > 4'd9 || alvo_dez > 3'd5 || int'(alvo_min) > MAX_MIN) return -1;
        return int'(alvo_min) * 60 + int'(alvo_dez) * 10 + int'(alvo_uni);
    endfunction

    function automatic void model_step(input logic t, input logic b, input logic l);
        int tg;
        tg = tgt_sec();
        if (l) begin
            m_sec = 0;
            m_st  = 0;
        end else if (m_st == 0) begin
            if (b) m_st = (m_sec == tg) ? 2 : 1;
        end else if (m_st == 1) begin
            if (b) m_st = 0;
            else if (t) begin
                if (m_sec == MAX_SEC) m_st = 2;
                else begin
                    m_sec = m_sec + 1;
                    if (m_sec == tg) m_st = 2;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_sec = 0;
        m_st  = 0;
    endfunction

    // scoreboard: push model expectation, pop and compare against DUT
    task automatic compare(input string tag);
        logic [12:0] e;
        exp_q.push_back({4'(m_sec / 60), 3'((m_sec % 60) / 10), 4'(m_sec % 10),
                         (m_st == 1), (m_st == 2)});
        e = exp_q.pop_front();
        check({tag, ".count"}, {5'd0, min, dez, uni}, {5'd0, e[12:2]});
        check({tag, ".flags"}, {14'd0, rodando, fim}, {14'd0, e[1:0]});
    endtask

    // driver: present inputs, take one edge, update model, check #1 later
    task automatic cyc(input string tag, input logic t, input logic b, input logic l);
        tick  = t;
        botao = b;
        limpa = l;
        @(posedge clock);
        model_step(t, b, l);
        #1;
        compare(tag);
        tick  = 1'b0;
        botao = 1'b0;
        limpa = 1'b0;
    endtask

    task automatic set_tgt(input int m, input int d, input int u);
        alvo_min = 4'(m);
        alvo_dez = 3'(d);
        alvo_uni = 4'(u);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        tick = 1'b0; botao = 1'b0; limpa = 1'b0;
        set_tgt(0, 0, 3);
        repeat (2) @(posedge clock);
        #1;
        compare("reset");
        @(negedge clock);
        resetn = 1'b1;

        // target 0:03, start, three ticks
        cyc("start", 1'b0, 1'b1, 1'b0);
        check("start.rodando", {15'd0, rodando}, 16'd1);
        ticks("t003", 3);
        check("t003.fim", {14'd0, rodando, fim}, 16'd1);
        check("t003.count", {5'd0, min, dez, uni}, 16'h003);

        // double carry 0:58 -> 0:59 -> 1:00
        set_tgt(2, 0, 0);
        cyc("clr1", 1'b0, 1'b0, 1'b1);
        cyc("go1", 1'b0, 1'b1, 1'b0);
        ticks("to058", 58);
        ticks("carry", 2);
        check("carry.count", {5'd0, min, dez, uni}, {5'd0, 4'd1, 3'd0, 4'd0});
        check("carry.rodando", {15'd0, rodando}, 16'd1);

        // pause with simultaneous tick, ignored ticks, resume
        set_tgt(9, 6, 0);
        cyc("clr2", 1'b0, 1'b0, 1'b1);
        cyc("go2", 1'b0, 1'b1, 1'b0);
        ticks("to005", 5);
        cyc("pause", 1'b1, 1'b1, 1'b0);
        check("pause.count", {5'd0, min, dez, uni}, 16'h005);
        ticks("paused", 3);
        cyc("resume", 1'b0, 1'b1, 1'b0);
        ticks("resume", 1);
        check("resume.count", {5'd0, min, dez, uni}, 16'h006);

        // ceiling with invalid target 9:60
        cyc("clr3", 1'b0, 1'b0, 1'b1);
        cyc("go3", 1'b0, 1'b1, 1'b0);
        ticks("to958", 598);
        ticks("ceil", 2);
        check("ceil.count", {5'd0, min, dez, uni}, {5'd0, 4'd9, 3'd5, 4'd9});
        check("ceil.fim", {15'd0, fim}, 16'd1);
        ticks("ceil.hold", 3);
        cyc("ceil.botao", 1'b0, 1'b1, 1'b0);
        cyc("ceil.clr", 1'b0, 1'b0, 1'b1);
        check("ceil.clr", {3'd0, min, dez, uni, rodando, fim}, 16'd0);

        // limpa beats botao and tick at 3:27
        cyc("go4", 1'b0, 1'b1, 1'b0);
        ticks("to327", 207);
        check("at327", {5'd0, min, dez, uni}, {5'd0, 4'd3, 3'd2, 4'd7});
        cyc("prio", 1'b1, 1'b1, 1'b1);

        // asynchronous reset between edges at 4:12
        cyc("go5", 1'b0, 1'b1, 1'b0);
        ticks("to412", 252);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare("async_rst");
        @(negedge clock);
        resetn = 1'b1;
        set_tgt(0, 0, 0);
        cyc("rst.go", 1'b0, 1'b1, 1'b0);
        check("rst.fim", {15'd0, fim}, 16'd1);

        // random traffic with occasional target changes (some invalid)
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0)
                set_tgt($urandom_range(0, 11), $urandom_range(0, 7), $urandom_range(0, 11));
            if (i % 400 == 200) set_tgt(15, 7, 15);
            cyc("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
